// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one 8N1 UART transmit line among four byte requesters.
// Each frame is granted to one requester and sent LSB-first, with bit timing taken from the system clock.
module uart_tx_scheduler #(
  parameter int unsigned CLK_HZ = 20000000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned CPB    = CLK_HZ / BAUD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  ack,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int unsigned CW = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [1:0]    r_rr_ptr;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [3:0]    r_ack;
  logic [1:0]    r_owner;
  logic          r_busy;
  logic          r_done;
  logic          r_tx;

  logic          w_found;
  logic [1:0]    w_winner;
  logic [1:0]    w_idx;
  logic          w_bit_end;

  // First requester at or after rr_ptr, wrapping modulo 4.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = r_rr_ptr + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  assign w_bit_end = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_ack     <= '0;
      r_owner   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_ack  <= '0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= '0;
          if (w_found) begin
            r_ack           <= '0;
            r_ack[w_winner] <= 1'b1;
            r_shift         <= data[8*w_winner +: 8];
            r_owner         <= w_winner;
            r_busy          <= 1'b1;
            r_tx            <= 1'b0;
            r_rr_ptr        <= w_winner + 2'd1;
            r_state         <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              // Next line level is taken from bit 1 because the shift lands on the same edge.
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack   = r_ack;
  assign owner = r_owner;
  assign busy  = r_busy;
  assign done  = r_done;
  assign tx    = r_tx;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART serial transmit line among four byte requesters.
- Round-robin arbitration: one requester is granted per frame.
- Sequences the 8N1 frame (start, 8 data bits LSB-first, stop) using an internal bit-period counter derived from the system clock, at the same 20 MHz / 9600 baud operating point as the existing baud generator.
- Sits between the on-chip byte producers and the uart tx pin.

Parameters:
- CLK_HZ, 20000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- CPB, CLK_HZ/BAUD (integer division, 2083 at defaults), clocks per bit.
  - Must be >= 2; counter width is clog2(CPB).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  4  per-requester transmit request; held until acked.
- data  in  32  packed bytes; requester i uses data[8*i+7:8*i]; must be stable while req[i] is high.
- ack  out  4  one-hot, one-cycle pulse: byte of that requester accepted.
- owner  out  2  index of the requester currently being transmitted; valid while busy.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at frame completion.
- tx  out  1  serial line; idle high.

Behaviour:
- Reset values, applied at a rising edge with reset=1 and overriding everything else:
  - tx=1, busy=0, ack=0, done=0, owner=0.
  - State IDLE, rr_ptr=0, bit counter=0, bit index=0.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1. If any req bit is high at a rising edge:
  - Winner: first set req bit, searching rr_ptr, rr_ptr+1, ... mod 4.
  - Same edge: ack[winner]=1 for exactly one cycle, shift register loaded with the winner's byte, owner=winner, busy=1, tx=0, state to START.
  - rr_ptr becomes (winner+1) mod 4.
- START: tx=0 for CPB cycles, then DATA with bit index 0.
- DATA: tx = shift[0] for CPB cycles per bit, shifting right each bit; after bit index 7 completes, go to STOP.
- STOP: tx=1 for CPB cycles. On its last cycle edge: state IDLE, busy=0, done=1 for one cycle.
- Frame length: exactly 10*CPB cycles from the ack edge to the done edge.
- The earliest next ack is the edge after done, so back-to-back frames start 10*CPB+1 cycles apart.
- The bit counter counts 0..CPB-1 and wraps to 0 at each bit boundary; no drift across bits.
- req/data changes while busy are ignored. A requester withdrawing req before ack simply loses that arbitration; no error.
- ack is never asserted while busy. At most one ack bit is high in any cycle.
- Reset mid-frame aborts the frame:
  - tx is high from the next cycle.
  - No done pulse; rr_ptr returns to 0.

Test Plan (CLK_HZ=40, BAUD=10, so CPB=4 and a frame is 40 cycles):
- Single request: req=0001, data[7:0]=0xA5.
  - ack=0001 for one cycle.
  - tx holds each level 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - done pulses 40 cycles after the ack edge; busy then drops.
- All-request contention: req=1111 held continuously with distinct bytes 0x11,0x22,0x33,0x44.
  - Acks in order 0001, 0010, 0100, 1000, each 41 cycles apart.
  - Corresponding bytes appear on tx.
- Round-robin fairness: req[1] and req[3] held permanently from reset.
  - Grants alternate 1,3,1,3; neither is granted twice in a row.
- Request during busy: req[2] raised 10 cycles into a frame owned by requester 0.
  - ack=0100 on the edge after done.
  - No ack while busy; owner=2 from that edge.
- Reset mid-frame: assert reset for 1 cycle at cycle 15 of a frame.
  - Next cycle: tx=1, busy=0, no done.
  - A following req=1010 grants requester 1 first (rr_ptr=0).
- Idle stability: no requests for 100 cycles.
  - tx=1, busy=0, ack=0, done=0 throughout.
